// File: rtl/gfx_pkg.sv
// Shared graphics definitions: screen geometry defaults, pending-write entry
// layout and the fill engine state encoding.
package gfx_pkg;

    localparam int SCREEN_WIDTH_DEFAULT  = 320;
    localparam int SCREEN_HEIGHT_DEFAULT = 240;

    typedef struct packed {
        logic [16:0] address;
        logic [7:0]  data;
    } pixel_write_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_t;

    // Framebuffer address is row-major with a 512-column pitch.
    function automatic logic [16:0] pixel_address(input logic [7:0] y, input logic [8:0] x);
        return {y, x};
    endfunction

endpackage

// File: rtl/fill_engine_stepper.sv
// Row-major raster walker over a latched rectangle; coordinates are kept widened
// so that right/bottom edges beyond the 9/8-bit address space never wrap.
import gfx_pkg::*;

module raster_stepper (
    input  logic       clock,
    input  logic       reset,
    input  logic       i_load,
    input  logic       i_step,
    input  logic [8:0] i_x0,
    input  logic [7:0] i_y0,
    input  logic [8:0] i_width,
    input  logic [7:0] i_height,
    output logic [9:0] o_cx,
    output logic [8:0] o_cy,
    output logic       o_last
);

    logic [9:0] r_cx;
    logic [8:0] r_cy;
    logic [9:0] r_x0;
    logic [9:0] r_x1;
    logic [8:0] r_y1;

    logic w_row_end;
    logic w_col_end;

    assign w_row_end = ((r_cx + 10'd1) == r_x1);
    assign w_col_end = ((r_cy + 9'd1) == r_y1);

    // Position and rectangle bounds: load on accept, advance one pixel per step.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_cx <= 10'd0;
            r_cy <= 9'd0;
            r_x0 <= 10'd0;
            r_x1 <= 10'd0;
            r_y1 <= 9'd0;
        end else if (i_load) begin
            r_x0 <= {1'b0, i_x0};
            r_x1 <= {1'b0, i_x0} + {1'b0, i_width};
            r_y1 <= {1'b0, i_y0} + {1'b0, i_height};
            r_cx <= {1'b0, i_x0};
            r_cy <= {1'b0, i_y0};
        end else if (i_step) begin
            if (w_row_end) begin
                r_cx <= r_x0;
                r_cy <= r_cy + 9'd1;
            end else begin
                r_cx <= r_cx + 10'd1;
            end
        end
    end

    assign o_cx   = r_cx;
    assign o_cy   = r_cy;
    assign o_last = w_row_end & w_col_end;

endmodule

// File: rtl/fill_engine.sv
// Rectangle fill engine: accepts a fill command and pushes one clipped pixel
// write per cycle into the memory manager's pending-write FIFO.
import gfx_pkg::*;

module fill_engine #(
    parameter int SCREEN_WIDTH  = SCREEN_WIDTH_DEFAULT,
    parameter int SCREEN_HEIGHT = SCREEN_HEIGHT_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmdValid,
    output logic        cmdReady,
    input  logic [8:0]  cmdX,
    input  logic [7:0]  cmdY,
    input  logic [8:0]  cmdWidth,
    input  logic [7:0]  cmdHeight,
    input  logic [7:0]  cmdColor,
    output logic [24:0] pendingWriteQueueWriteBus,
    output logic        pendingWriteQueueWriteRequest,
    input  logic        pendingWriteQueueWriteFull,
    output logic        busy,
    output logic        fillDone
);

    fill_state_t r_state;
    fill_state_t w_next_state;
    logic        r_fill_done;
    logic        w_fill_done_next;
    logic [7:0]  r_color;

    logic [9:0]   w_cx;
    logic [8:0]   w_cy;
    logic         w_last;
    logic         w_busy;
    logic         w_ready;
    logic         w_accept;
    logic         w_empty_cmd;
    logic         w_in_bounds;
    logic         w_push;
    logic         w_step;
    pixel_write_t w_pixel;

    assign w_busy      = (r_state == FILL);
    assign w_ready     = reset & (r_state == IDLE);
    assign w_accept    = cmdValid & w_ready;
    assign w_empty_cmd = (cmdWidth == 9'd0) | (cmdHeight == 8'd0);
    assign w_in_bounds = (w_cx < 10'(SCREEN_WIDTH)) & (w_cy < 9'(SCREEN_HEIGHT));
    assign w_push      = reset & w_busy & w_in_bounds & ~pendingWriteQueueWriteFull;
    // Off-screen pixels are skipped regardless of FIFO backpressure.
    assign w_step      = w_busy & (~w_in_bounds | ~pendingWriteQueueWriteFull);

    raster_stepper u_stepper (
        .clock    (clock),
        .reset    (reset),
        .i_load   (w_accept),
        .i_step   (w_step),
        .i_x0     (cmdX),
        .i_y0     (cmdY),
        .i_width  (cmdWidth),
        .i_height (cmdHeight),
        .o_cx     (w_cx),
        .o_cy     (w_cy),
        .o_last   (w_last)
    );

    // Next-state and completion-pulse decode.
    always_comb begin
        w_next_state     = r_state;
        w_fill_done_next = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept && !w_empty_cmd) begin
                    w_next_state = FILL;
                end else if (w_accept) begin
                    w_fill_done_next = 1'b1;
                end else begin
                    w_next_state = IDLE;
                end
            end
            FILL: begin
                if (w_step && w_last) begin
                    w_next_state     = IDLE;
                    w_fill_done_next = 1'b1;
                end else begin
                    w_next_state = FILL;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // State, done pulse and latched fill colour.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_fill_done <= 1'b0;
            r_color     <= 8'd0;
        end else begin
            r_state     <= w_next_state;
            r_fill_done <= w_fill_done_next;
            if (w_accept) begin
                r_color <= cmdColor;
            end
        end
    end

    // Current pixel entry; the bus is parked at zero when no command is active.
    always_comb begin
        w_pixel.address = pixel_address(w_cy[7:0], w_cx[8:0]);
        w_pixel.data    = r_color;
        if (w_busy) begin
            pendingWriteQueueWriteBus = w_pixel;
        end else begin
            pendingWriteQueueWriteBus = 25'd0;
        end
    end

    assign pendingWriteQueueWriteRequest = w_push;
    assign cmdReady                      = w_ready;
    assign busy                          = w_busy;
    assign fillDone                      = r_fill_done;

endmodule
